// File: rtl/flex_ds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flex_ds_pkg
// Description : Shared types and helpers for the flex_downsample_stream block:
//               frame FSM state encoding, Q8.8 stride constants and the
//               frame-configuration legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package flex_ds_pkg;

  localparam int Q88_FRAC = 8;   // fractional bits of the Q8.8 stride
  localparam int STRIDE_W = 16;  // total stride width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A configuration is legal when the last requested output index still maps
  // onto an existing input row/column; everything is evaluated in 32 bits so
  // the product (hout-1)*stride cannot overflow.
  function automatic logic cfg_valid(input int unsigned hin,
                                     input int unsigned hout,
                                     input int unsigned stride,
                                     input int unsigned hin_max);
    int unsigned span;
    if (hin < 1 || hout < 1 || hout > hin || hin > hin_max || stride < 256)
      return 1'b0;
    span = ((hout - 1) * stride) >> Q88_FRAC;
    return (span <= hin - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flex_downsample_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : flex_downsample_stream_if
// Description : Pixel stream bundle for flex_downsample_stream.
//               in_valid/in_ready/in_data : input pixel handshake
//               out_valid/out_ready/out_data/out_last : output pixel handshake
//               master : the environment (feeds pixels, consumes output)
//               slave  : the downsampler
// Revision    : 1.0 - initial release
// ============================================================================
interface flex_downsample_stream_if #(
  parameter int DATA_W = 8,
  parameter int CIN    = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CIN*DATA_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CIN*DATA_W-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/flex_ds_index_gen.sv
`default_nettype none
// ============================================================================
// Module      : flex_ds_index_gen
// Description : One axis of the nearest-neighbour selector. Tracks the current
//               input index, a Q8.8 target accumulator and the number of
//               outputs already emitted on this axis.
//               clk, rst_n : clock, async active-low reset
//               init       : clear all state (frame start)
//               adv        : one input position on this axis was consumed
//               hin, hout  : latched input / output size
//               stride     : latched Q8.8 stride
//               idx, cnt   : current input index / emitted count
//               hit        : current index is the next selected one
//               at_last    : current index is hin-1 (wraps on adv)
// Revision    : 1.0 - initial release
// ============================================================================
module flex_ds_index_gen
  import flex_ds_pkg::*;
#(
  parameter int HW = 6,  // index / size width
  parameter int IW = 6   // integer bits of the accumulator
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                adv,
  input  logic [HW-1:0]       hin,
  input  logic [HW-1:0]       hout,
  input  logic [STRIDE_W-1:0] stride,
  output logic [HW-1:0]       idx,
  output logic [HW-1:0]       cnt,
  output logic                hit,
  output logic                at_last
);

  localparam int ACC_W = Q88_FRAC + IW;

  logic [HW-1:0]    r_idx;
  logic [HW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [IW-1:0]    w_tgt;

  // Target index is the integer part of the accumulator (floor, no rounding).
  assign w_tgt   = r_acc[ACC_W-1:Q88_FRAC];
  assign hit     = (IW'(r_idx) == w_tgt) && (r_cnt < hout);
  assign at_last = (r_idx == (hin - HW'(1)));
  assign idx     = r_idx;
  assign cnt     = r_cnt;

  // Once all hout positions are emitted the accumulator may wrap; the
  // r_cnt < hout term in hit keeps a wrapped target from selecting again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (init) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (adv) begin
      if (at_last) begin
        r_idx <= '0;
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_idx <= r_idx + HW'(1);
        if (hit) begin
          r_acc <= r_acc + ACC_W'(stride);
          r_cnt <= r_cnt + HW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flex_downsample_stream.sv
`default_nettype none
// ============================================================================
// Module      : flex_downsample_stream
// Description : Nearest-neighbour spatial downsampler on a row-major pixel
//               stream. Keeps input pixel (floor(i*s), floor(j*s)) for every
//               output (i,j), s = cfg_stride/256, and forwards it unmodified.
//               clk, rst_n             : clock, async active-low reset
//               start                  : frame start pulse (IDLE only)
//               cfg_hin/cfg_hout       : input / output square size
//               cfg_stride             : Q8.8 stride
//               bus (slave)            : in/out pixel handshakes, out_last
//               done                   : one-cycle frame completion pulse
//               cfg_err                : one-cycle rejected-config pulse
// Revision    : 1.0 - initial release
// ============================================================================
module flex_downsample_stream
  import flex_ds_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CIN     = 64,
  parameter int HIN_MAX = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(HIN_MAX+1)-1:0]  cfg_hin,
  input  logic [$clog2(HIN_MAX+1)-1:0]  cfg_hout,
  input  logic [STRIDE_W-1:0]           cfg_stride,
  flex_downsample_stream_if.slave       bus,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int HW = $clog2(HIN_MAX+1);
  localparam int IW = $clog2(HIN_MAX) + 1;
  localparam int W  = CIN * DATA_W;

  state_t                r_state;
  logic [HW-1:0]         r_hin;
  logic [HW-1:0]         r_hout;
  logic [STRIDE_W-1:0]   r_stride;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [W-1:0]          r_out_data;
  logic                  r_done;
  logic                  r_cfg_err;

  logic                  w_cfg_ok;
  logic                  w_start_ok;
  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_keep;
  logic                  w_is_last;
  logic                  w_frame_end;
  logic                  w_row_hit, w_col_hit;
  logic                  w_row_last, w_col_last;
  logic [HW-1:0]         w_row_idx, w_col_idx;
  logic [HW-1:0]         w_row_cnt, w_col_cnt;

  assign w_cfg_ok   = cfg_valid(32'(cfg_hin), 32'(cfg_hout), 32'(cfg_stride), HIN_MAX);
  assign w_start_ok = (r_state == ST_IDLE) && start && w_cfg_ok;

  // Accept whenever the output register is free or being emptied this cycle.
  assign w_in_ready  = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_keep      = w_row_hit && w_col_hit;
  assign w_is_last   = (w_row_cnt == (r_hout - HW'(1))) && (w_col_cnt == (r_hout - HW'(1)));
  assign w_frame_end = w_acc && w_row_last && w_col_last;

  // Column axis steps on every accepted beat; the row axis steps on the
  // beat that closes a row. Both clear on their own wrap.
  flex_ds_index_gen #(.HW(HW), .IW(IW)) u_col (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (w_start_ok),
    .adv     (w_acc),
    .hin     (r_hin),
    .hout    (r_hout),
    .stride  (r_stride),
    .idx     (w_col_idx),
    .cnt     (w_col_cnt),
    .hit     (w_col_hit),
    .at_last (w_col_last)
  );

  flex_ds_index_gen #(.HW(HW), .IW(IW)) u_row (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (w_start_ok),
    .adv     (w_acc && w_col_last),
    .hin     (r_hin),
    .hout    (r_hout),
    .stride  (r_stride),
    .idx     (w_row_idx),
    .cnt     (w_row_cnt),
    .hit     (w_row_hit),
    .at_last (w_row_last)
  );

  // Frame control FSM with registered done/cfg_err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hin     <= '0;
      r_hout    <= '0;
      r_stride  <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_hin    <= cfg_hin;
              r_hout   <= cfg_hout;
              r_stride <= cfg_stride;
              r_state  <= ST_RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_frame_end) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave as soon as the held pixel (if any) is taken.
          if (!r_out_valid || bus.out_ready) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output pixel register; a reload in the same cycle as a handshake keeps
  // out_valid high so back-to-back kept beats flow without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_acc && w_keep) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_is_last;
      r_out_data  <= bus.in_data;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
  assign done          = r_done;
  assign cfg_err       = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_flex_downsample_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_downsample_stream
// Description : Directed self-checking bench for flex_downsample_stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_flex_downsample_stream;

  localparam int DATA_W  = 8;
  localparam int CIN     = 64;
  localparam int HIN_MAX = 32;
  localparam int W       = CIN * DATA_W;
  localparam int HW      = $clog2(HIN_MAX+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [HW-1:0] cfg_hin = '0;
  logic [HW-1:0] cfg_hout = '0;
  logic [15:0]   cfg_stride = '0;
  logic          done;
  logic          cfg_err;

  flex_downsample_stream_if #(.DATA_W(DATA_W), .CIN(CIN)) bus ();

  flex_downsample_stream #(.DATA_W(DATA_W), .CIN(CIN), .HIN_MAX(HIN_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_hin    (cfg_hin),
    .cfg_hout   (cfg_hout),
    .cfg_stride (cfg_stride),
    .bus        (bus),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  bit rnd_rdy = 1'b0;
  logic [W-1:0] q_data[$];
  bit           q_last[$];
  int           exp_idx[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  int k33 [19] = '{0,1,2,4,5,7,8,10,11,12,14,15,17,18,20,21,23,24,25};
  int k34 [4]  = '{0,2,4,6};
  int k35 [5]  = '{0,1,2,3,4};

  function automatic logic [W-1:0] pix(input int r, input int c);
    logic [W-1:0] v;
    for (int k = 0; k < CIN; k++) v[k*DATA_W +: DATA_W] = DATA_W'(k*5 + r*3 + c*7 + 1);
    v[7:0]  = 8'(r);
    v[15:8] = 8'(c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: logs handshakes, checks hold-under-stall, counts done.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", W'(bus.out_valid), W'(1));
          chk("stall_data", bus.out_data, prev_data);
          chk("stall_last", W'(bus.out_last), W'(prev_last));
        end
        if (bus.out_valid && bus.out_ready) begin
          q_data.push_back(bus.out_data);
          q_last.push_back(bus.out_last);
          last_hs_cyc = cyc;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Output back-pressure driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input int hin, input int hout, input int stride, input bit ok);
    q_data.delete();
    q_last.delete();
    done_cnt = 0;
    cfg_hin    = HW'(hin);
    cfg_hout   = HW'(hout);
    cfg_stride = 16'(stride);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ok) begin
      chk("start_in_ready", W'(bus.in_ready), W'(1));
      chk("start_cfg_err", W'(cfg_err), W'(0));
    end else begin
      chk("bad_cfg_err_pulse", W'(cfg_err), W'(1));
      chk("bad_cfg_in_ready", W'(bus.in_ready), W'(0));
      @(posedge clk);
      #1;
      chk("bad_cfg_err_clear", W'(cfg_err), W'(0));
      chk("bad_cfg_idle", W'(bus.in_ready), W'(0));
    end
  endtask

  task automatic send_frame(input int hin, input bit gaps, input int max_beats, input bit chk_lat);
    int beats = 0;
    bit lat_pend = 1'b0;
    logic [W-1:0] lat_data = '0;
    for (int r = 0; r < hin; r++) begin
      for (int c = 0; c < hin; c++) begin
        bit acc = 1'b0;
        int guard = 0;
        if (beats == max_beats) begin
          bus.in_valid = 1'b0;
          return;
        end
        while (gaps && $urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = pix(r, c);
        while (!acc && guard < 2000) begin
          @(negedge clk);
          if (lat_pend) begin
            chk("latency_valid", W'(bus.out_valid), W'(1));
            chk("latency_data", bus.out_data, lat_data);
            lat_pend = 1'b0;
          end
          acc = bus.in_ready;
          @(posedge clk);
          #1;
          guard++;
        end
        if (!acc) chk("in_accept_timeout", W'(acc), W'(1));
        lat_pend = chk_lat;
        lat_data = pix(r, c);
        beats++;
      end
    end
    bus.in_valid = 1'b0;
    if (lat_pend) begin
      @(negedge clk);
      chk("latency_valid", W'(bus.out_valid), W'(1));
      chk("latency_data", bus.out_data, lat_data);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, W'(done_cnt != 0), W'(1));
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, W'(done_cnt), W'(1));
    chk({tag, "_idle_in_ready"}, W'(bus.in_ready), W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    int n = exp_idx.size();
    chk({tag, "_count"}, W'(q_data.size()), W'(n*n));
    for (int i = 0; i < n*n && i < q_data.size(); i++) begin
      chk($sformatf("%s_data[%0d]", tag, i), q_data[i], pix(exp_idx[i/n], exp_idx[i%n]));
      chk($sformatf("%s_last[%0d]", tag, i), W'(q_last[i]), W'(i == n*n-1));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(bus.in_ready), W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_last", W'(bus.out_last), W'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_done", W'(done), W'(0));
    chk("rst_cfg_err", W'(cfg_err), W'(0));

    // 5x5 stride 1.0 pass-through, start right after reset release.
    rst_n = 1'b1;
    start_frame(5, 5, 256, 1'b1);
    send_frame(5, 1'b0, 1000, 1'b1);
    wait_done("pass");
    exp_idx.delete();
    foreach (k35[i]) exp_idx.push_back(k35[i]);
    check_frame("pass");
    chk("pass_done_latency", W'(done_cyc), W'(last_hs_cyc + 1));

    // Rejected configurations.
    start_frame(27, 19, 200, 1'b0);
    start_frame(8, 9, 512, 1'b0);

    // 8 -> 4, stride 2.0.
    start_frame(8, 4, 512, 1'b1);
    send_frame(8, 1'b0, 1000, 1'b0);
    wait_done("half");
    exp_idx.delete();
    foreach (k34[i]) exp_idx.push_back(k34[i]);
    check_frame("half");

    // 27 -> 19, stride 1.441.
    start_frame(27, 19, 369, 1'b1);
    send_frame(27, 1'b0, 1000, 1'b0);
    wait_done("frac");
    exp_idx.delete();
    foreach (k33[i]) exp_idx.push_back(k33[i]);
    check_frame("frac");

    // Same frame with input gaps and random back-pressure.
    rnd_rdy = 1'b1;
    start_frame(27, 19, 369, 1'b1);
    send_frame(27, 1'b1, 1000, 1'b0);
    wait_done("stall");
    rnd_rdy = 1'b0;
    check_frame("stall");

    // Mid-frame reset after 100 beats, then a clean 8 -> 4 frame.
    start_frame(27, 19, 369, 1'b1);
    send_frame(27, 1'b0, 100, 1'b0);
    chk("midrst_running", W'(bus.in_ready), W'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(bus.out_valid), W'(0));
    chk("midrst_out_last", W'(bus.out_last), W'(0));
    chk("midrst_out_data", bus.out_data, '0);
    chk("midrst_in_ready", W'(bus.in_ready), W'(0));
    chk("midrst_done", W'(done), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_frame(8, 4, 512, 1'b1);
    send_frame(8, 1'b0, 1000, 1'b0);
    wait_done("post_rst");
    exp_idx.delete();
    foreach (k34[i]) exp_idx.push_back(k34[i]);
    check_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
